spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master controller: two-requester round-robin arbiter, chip-select
// sequencing (setup/transfer/hold) and SCLK/strobe generation for an
// external TX/RX shifter pair. Every output comes straight from a flop.
module spi_master_ctrl #(
  parameter int DLY        = 1,
  parameter int FIFO_WIDTH = 32,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cpol,
  input  logic       cpoa,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic [1:0] done_o,
  output logic       busy_o,
  output logic [1:0] cs_n_o,
  output logic       sclk_o,
  output logic       frame_start_o,
  output logic       shift_o,
  output logic       bit_en_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int CNT_W  = $clog2(2 * FIFO_WIDTH + 1);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  // The register update delay has no cycle-level effect in this implementation;
  // it is range-checked together with the timing parameters at elaboration.
  if (CLK_DIV < 2 || CS_SETUP < 1 || CS_HOLD < 1 || FIFO_WIDTH < 1 || DLY < 0) begin : g_param_chk
    $error("spi_master_ctrl: illegal parameter set");
  end

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             sclk_q, sclk_d;
  logic             fs_q, fs_d;
  logic             shift_q, shift_d;
  logic             bit_en_q, bit_en_d;
  logic             cpol_q, cpol_d;
  logic             cpoa_q, cpoa_d;
  logic             last_q, last_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] bit_q, bit_d;

  logic             win_s;
  logic             div_tc_s;
  logic             sample_edge_s;
  logic [CNT_W-1:0] edge_nxt_s;

  // Next-state logic: arbitration, phase sequencing, SCLK divider and strobes.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    fs_d     = 1'b0;
    shift_d  = 1'b0;
    bit_en_d = 1'b0;
    cpol_d   = cpol_q;
    cpoa_d   = cpoa_q;
    last_d   = last_q;
    div_d    = div_q;
    ph_d     = ph_q;
    edge_d   = edge_q;
    bit_d    = bit_q;

    // Round-robin: on a tie the requester not granted last time wins.
    case (req_i)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ~last_q;
      default: win_s = last_q;
    endcase

    div_tc_s      = (div_q == DIV_W'(CLK_DIV - 1));
    edge_nxt_s    = edge_q + 1'b1;
    // Odd edges sample when cpoa=0, even edges sample when cpoa=1.
    sample_edge_s = edge_nxt_s[0] ^ cpoa_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        if (req_i != 2'b00) begin
          state_d = S_SETUP;
          gnt_d   = win_s ? 2'b10 : 2'b01;
          cs_n_d  = win_s ? 2'b01 : 2'b10;
          last_d  = win_s;
          cpol_d  = cpol;
          cpoa_d  = cpoa;
          busy_d  = 1'b1;
          div_d   = '0;
          ph_d    = '0;
          edge_d  = '0;
          bit_d   = '0;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_SETUP: begin
        sclk_d = cpol_q;
        if (ph_q == PH_W'(CS_SETUP - 1)) begin
          state_d = S_XFER;
          ph_d    = '0;
          fs_d    = 1'b1;
          // With cpoa=0 the first bit must be on the wire before edge 1.
          shift_d = ~cpoa_q;
        end else begin
          ph_d    = ph_q + 1'b1;
        end
      end
      S_XFER: begin
        if (div_tc_s) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_nxt_s;
          if (sample_edge_s) begin
            bit_en_d = 1'b1;
            bit_d    = bit_q + 1'b1;
          end else begin
            // No launch after the final sample: the frame is complete.
            shift_d  = (bit_q != CNT_W'(FIFO_WIDTH));
          end
          if (edge_q == CNT_W'(2 * FIFO_WIDTH - 1)) begin
            state_d = S_HOLD;
            ph_d    = '0;
          end else begin
            state_d = S_XFER;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (ph_q == PH_W'(CS_HOLD - 1)) begin
          state_d = S_IDLE;
          cs_n_d  = 2'b11;
          gnt_d   = 2'b00;
          done_d  = gnt_q;
          busy_d  = 1'b0;
          sclk_d  = cpol;
          ph_d    = '0;
        end else begin
          ph_d    = ph_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        cs_n_d  = 2'b11;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the idle state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      cs_n_q   <= 2'b11;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      fs_q     <= 1'b0;
      shift_q  <= 1'b0;
      bit_en_q <= 1'b0;
      cpol_q   <= 1'b0;
      cpoa_q   <= 1'b0;
      last_q   <= 1'b1;
      div_q    <= '0;
      ph_q     <= '0;
      edge_q   <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      sclk_q   <= sclk_d;
      fs_q     <= fs_d;
      shift_q  <= shift_d;
      bit_en_q <= bit_en_d;
      cpol_q   <= cpol_d;
      cpoa_q   <= cpoa_d;
      last_q   <= last_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign cs_n_o        = cs_n_q;
  assign sclk_o        = sclk_q;
  assign frame_start_o = fs_q;
  assign shift_o       = shift_q;
  assign bit_en_o      = bit_en_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl
// (FIFO_WIDTH=8, CLK_DIV=2, CS_SETUP=2, CS_HOLD=2).
module tb_spi_master_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       cpol = 1'b0;
  logic       cpoa = 1'b0;
  logic [1:0] req_i = 2'b00;
  logic [1:0] gnt_o;
  logic [1:0] done_o;
  logic       busy_o;
  logic [1:0] cs_n_o;
  logic       sclk_o;
  logic       frame_start_o;
  logic       shift_o;
  logic       bit_en_o;

  int n_checks = 0;
  int n_fail   = 0;

  spi_master_ctrl #(
    .DLY(1), .FIFO_WIDTH(8), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cpol(cpol), .cpoa(cpoa),
    .req_i(req_i), .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
    .cs_n_o(cs_n_o), .sclk_o(sclk_o), .frame_start_o(frame_start_o),
    .shift_o(shift_o), .bit_en_o(bit_en_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // {gnt,done,busy,cs_n,sclk,frame_start,shift,bit_en}
  task automatic check_reset_vals(input string tag);
    check(tag, {21'd0, gnt_o, done_o, busy_o, cs_n_o, sclk_o, frame_start_o, shift_o, bit_en_o},
          {21'd0, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic apply_reset(input string tag);
    rst_n_i = 1'b0;
    tick();
    tick();
    check_reset_vals(tag);
    rst_n_i = 1'b1;
  endtask

  // Samples 33 cycles from the first XFER cycle through the first HOLD cycle.
  task automatic xfer_window(input int drop_at, output int edges, output int nbit,
                             output int nbit_rise, output int nshift,
                             output int nshift_fall, output int nfs);
    logic prev;
    logic edge_now;
    prev = sclk_o;
    edges = 0; nbit = 0; nbit_rise = 0; nshift = 0; nshift_fall = 0; nfs = 0;
    for (int i = 0; i < 33; i++) begin
      tick();
      edge_now = (sclk_o !== prev);
      if (edge_now) edges++;
      if (bit_en_o) begin
        nbit++;
        if (edge_now && sclk_o) nbit_rise++;
      end
      if (shift_o) begin
        nshift++;
        if (edge_now && !sclk_o) nshift_fall++;
      end
      if (frame_start_o) nfs++;
      prev = sclk_o;
      if (i == drop_at) begin
        req_i = 2'b00;
        cpol  = ~cpol;
      end
    end
  endtask

  // One complete frame from IDLE; drop_at<0 releases the request right after grant.
  task automatic run_frame(input string tag, input logic [1:0] rq, input logic pol,
                           input logic pha, input int drop_at,
                           input int exp_bit_rise, input int exp_shift_fall);
    int edges, nbit, nbit_rise, nshift, nshift_fall, nfs;
    cpol  = pol;
    cpoa  = pha;
    req_i = rq;
    tick();
    check({tag, "_grant"}, {27'd0, gnt_o, cs_n_o, busy_o}, {27'd0, rq, ~rq, 1'b1});
    check({tag, "_setup_sclk"}, {31'd0, sclk_o}, {31'd0, pol});
    if (drop_at < 0) req_i = 2'b00;
    tick();
    check({tag, "_setup2"}, {29'd0, sclk_o, busy_o, frame_start_o}, {29'd0, pol, 1'b1, 1'b0});
    xfer_window(drop_at, edges, nbit, nbit_rise, nshift, nshift_fall, nfs);
    check({tag, "_edges"}, edges, 16);
    check({tag, "_bit_en"}, nbit, 8);
    check({tag, "_shift"}, nshift, 8);
    check({tag, "_frame_start"}, nfs, 1);
    check({tag, "_bit_en_rise"}, nbit_rise, exp_bit_rise);
    check({tag, "_shift_fall"}, nshift_fall, exp_shift_fall);
    check({tag, "_hold1"}, {27'd0, cs_n_o, sclk_o, busy_o, done_o[0]}, {27'd0, ~rq, pol, 1'b1, 1'b0});
    tick();
    check({tag, "_hold2"}, {26'd0, cs_n_o, sclk_o, busy_o, done_o}, {26'd0, ~rq, pol, 1'b1, 2'b00});
    tick();
    check({tag, "_done"}, {25'd0, done_o, gnt_o, cs_n_o, busy_o}, {25'd0, rq, 2'b00, 2'b11, 1'b0});
    check({tag, "_idle_sclk"}, {31'd0, sclk_o}, {31'd0, cpol});
    tick();
    check({tag, "_done_clear"}, {30'd0, done_o}, 32'd0);
  endtask

  initial begin
    logic [1:0] order [3];
    int         ng, idle_run, gap_min, done0, done1, edges;
    logic [1:0] prev_gnt;
    logic       prev_busy, prev_sclk, seen_busy, found;

    // Reset state, then a basic mode-0 frame from requester 0.
    apply_reset("reset");
    run_frame("m0_r0", 2'b01, 1'b0, 1'b0, -1, 8, 7);

    // IDLE sclk tracks cpol with one cycle of latency.
    cpol = 1'b1;
    check("idle_sclk_before", {31'd0, sclk_o}, 32'd0);
    tick();
    check("idle_sclk_after", {31'd0, sclk_o}, 32'd1);

    // Mode 3 from requester 1: idles high, launch on falling, sample on rising.
    run_frame("m3_r1", 2'b10, 1'b1, 1'b1, -1, 8, 8);

    // Request dropped and cpol flipped mid-transfer: frame is unaffected.
    run_frame("drop", 2'b01, 1'b0, 1'b0, 10, 8, 7);

    // Both requesters held from reset: 0, 1, 0 with idle gaps.
    cpol = 1'b0; cpoa = 1'b0;
    req_i = 2'b11;
    apply_reset("reset_arb");
    ng = 0; idle_run = 0; gap_min = 1000; done0 = 0; done1 = 0;
    prev_gnt = 2'b00; prev_busy = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (gnt_o != 2'b00 && prev_gnt == 2'b00 && ng < 3) begin
        order[ng] = gnt_o;
        ng++;
      end
      if (busy_o && !prev_busy && seen_busy && idle_run < gap_min) gap_min = idle_run;
      if (busy_o) begin
        seen_busy = 1'b1;
        idle_run  = 0;
      end else begin
        idle_run++;
      end
      if (done_o[0]) done0++;
      if (done_o[1]) done1++;
      prev_gnt  = gnt_o;
      prev_busy = busy_o;
    end
    check("arb_count", ng, 3);
    check("arb_first", {30'd0, order[0]}, 32'h1);
    check("arb_second", {30'd0, order[1]}, 32'h2);
    check("arb_third", {30'd0, order[2]}, 32'h1);
    check("arb_idle_gap", {31'd0, (gap_min >= 1 && gap_min < 1000)}, 32'd1);
    check("arb_done0", done0, 2);
    check("arb_done1", done1, 1);
    req_i = 2'b00;

    // Reset at the 7th XFER edge aborts the frame without done.
    apply_reset("reset_abort");
    cpol = 1'b0; cpoa = 1'b0;
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    tick();
    prev_sclk = sclk_o; edges = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (sclk_o !== prev_sclk) edges++;
      prev_sclk = sclk_o;
      if (edges == 7) found = 1'b1;
    end
    check("abort_edge7_found", {31'd0, found}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    check_reset_vals("abort_async");
    tick();
    req_i = 2'b10;
    rst_n_i = 1'b1;
    tick();
    check("abort_regrant", {28'd0, gnt_o, cs_n_o}, {28'd0, 2'b10, 2'b01});
    check("abort_no_done", {30'd0, done_o}, 32'd0);

    // Last-grant returns to its power-up value: a tie after reset goes to 0.
    apply_reset("reset_rr");
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    tick();
    rst_n_i = 1'b0;
    tick();
    req_i = 2'b11;
    rst_n_i = 1'b1;
    tick();
    check("rr_after_reset", {30'd0, gnt_o}, 32'h1);
    req_i = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
